// File: rtl/arkanoid_pkg.sv
// Shared definitions for the Arkanoid datapath blocks: ball state encoding and screen geometry.
package arkanoid_pkg;

  localparam int DEFAULT_SCREEN_W = 640;
  localparam int DEFAULT_SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_MOVE  = 2'd1,
    ST_LOST  = 2'd2
  } ball_state_t;

endpackage

// File: rtl/arkanoid_ball_if.sv
// Frame/pixel inputs and ball outputs of the ball engine, bundled for the game top level.
interface arkanoid_ball_if;

  logic       i_animate;
  logic       i_launch;
  logic [9:0] i_paddle_x;
  logic [9:0] i_x;
  logic [8:0] i_y;

  logic [9:0] o_ball_x;
  logic [8:0] o_ball_y;
  logic       o_draw;
  logic [1:0] o_state;
  logic       o_bounce;
  logic       o_lost;

  modport master (
    output i_animate, i_launch, i_paddle_x, i_x, i_y,
    input  o_ball_x, o_ball_y, o_draw, o_state, o_bounce, o_lost
  );

  modport slave (
    input  i_animate, i_launch, i_paddle_x, i_x, i_y,
    output o_ball_x, o_ball_y, o_draw, o_state, o_bounce, o_lost
  );

endinterface

// File: rtl/edge_tick.sv
// Rising-edge detector: one tick per high period of a level that may stay high for many cycles.
module edge_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic tick
);

  logic level_q;

  // NOTE: registers are written with <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign tick = level & ~level_q;

endmodule

// File: rtl/arkanoid_ball.sv
// Ball motion engine: advances the ball once per frame tick (serve/move/lost) and flags ball pixels.
module arkanoid_ball
  import arkanoid_pkg::*;
#(
  parameter int SCREEN_W    = DEFAULT_SCREEN_W,
  parameter int SCREEN_H    = DEFAULT_SCREEN_H,
  parameter int BALL_SIZE   = 8,
  parameter int SPEED       = 2,
  parameter int PADDLE_Y    = 440,
  parameter int PADDLE_W    = 64,
  parameter int LOST_FRAMES = 60
) (
  input logic            i_clk,
  input logic            i_rst_n,
  arkanoid_ball_if.slave bus
);

  localparam int CW = $clog2(LOST_FRAMES + 1);

  localparam logic [9:0]  X_MAX   = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [9:0]  X_RESET = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [8:0]  Y_SERVE = 9'(PADDLE_Y - BALL_SIZE);
  localparam logic [10:0] RIDE_OFS = 11'(PADDLE_W / 2 - BALL_SIZE / 2);

  // Signed copies so wall tests stay correct when a step goes past zero.
  localparam logic signed [10:0] SPEED_S  = 11'(SPEED);
  localparam logic signed [10:0] BALL_S   = 11'(BALL_SIZE);
  localparam logic signed [10:0] X_MAX_S  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic signed [10:0] PADDLE_S = 11'(PADDLE_Y);
  localparam logic signed [10:0] BOTTOM_S = 11'(SCREEN_H);
  localparam logic signed [11:0] BALL_W   = 12'(BALL_SIZE);
  localparam logic signed [11:0] PAD_W    = 12'(PADDLE_W);

  ball_state_t   state_q, state_d;
  logic [9:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic          dx_pos_q, dx_pos_d;
  logic          dy_pos_q, dy_pos_d;
  logic          launch_q, launch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bounce_q, bounce_d;
  logic          lost_q, lost_d;
  logic          draw_q, draw_d;

  logic tick;

  edge_tick u_edge_tick (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .level (bus.i_animate),
    .tick  (tick)
  );

  logic signed [10:0] cur_x, cur_y, nx, ny;
  logic signed [11:0] nx_w, px_w;
  logic [10:0]        ride_x;
  logic [9:0]         ride_clamped;
  logic               launch_req;
  logic               hit_left, hit_right, hit_top, hit_bottom, paddle_hit;
  logic               bounce_x, bounce_y;
  logic [9:0]         rel_x;
  logic [8:0]         rel_y;

  assign cur_x = {1'b0, x_q};
  assign cur_y = {2'b00, y_q};
  assign nx    = dx_pos_q ? cur_x + SPEED_S : cur_x - SPEED_S;
  assign ny    = dy_pos_q ? cur_y + SPEED_S : cur_y - SPEED_S;

  // Overlap terms get one extra bit: paddle_x + PADDLE_W can exceed the 11-bit signed range.
  assign nx_w = {nx[10], nx};
  assign px_w = {2'b00, bus.i_paddle_x};

  assign hit_left   = (nx <= 11'sd0);
  assign hit_right  = (nx >= X_MAX_S);
  assign hit_top    = (ny <= 11'sd0);
  assign hit_bottom = (ny + BALL_S >= BOTTOM_S);
  assign paddle_hit = dy_pos_q
                   && (ny + BALL_S >= PADDLE_S)
                   && (cur_y + BALL_S <= PADDLE_S)
                   && (nx_w + BALL_W > px_w)
                   && (nx_w < px_w + PAD_W);

  assign ride_x       = {1'b0, bus.i_paddle_x} + RIDE_OFS;
  assign ride_clamped = (ride_x > {1'b0, X_MAX}) ? X_MAX : ride_x[9:0];

  // The latch is only armed in SERVE; a tick in the same cycle consumes the button directly.
  assign launch_req = launch_q || bus.i_launch;

  // NOTE: every variable gets its default first so no path through the case can infer a latch.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_pos_d = dx_pos_q;
    dy_pos_d = dy_pos_q;
    cnt_d    = cnt_q;
    bounce_d = 1'b0;
    lost_d   = 1'b0;
    bounce_x = 1'b0;
    bounce_y = 1'b0;
    launch_d = (state_q == ST_SERVE) && !tick && launch_req;

    if (tick) begin
      unique case (state_q)
        ST_SERVE: begin
          if (launch_req) begin
            state_d  = ST_MOVE;
            dx_pos_d = 1'b1;
            dy_pos_d = 1'b0;
          end else begin
            x_d = ride_clamped;
            y_d = Y_SERVE;
          end
        end

        ST_MOVE: begin
          if (hit_bottom && !paddle_hit) begin
            state_d = ST_LOST;
            lost_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            if (hit_left) begin
              x_d      = '0;
              dx_pos_d = 1'b1;
              bounce_x = 1'b1;
            end else if (hit_right) begin
              x_d      = X_MAX;
              dx_pos_d = 1'b0;
              bounce_x = 1'b1;
            end else begin
              x_d = nx[9:0];
            end

            if (hit_top) begin
              y_d      = '0;
              dy_pos_d = 1'b1;
              bounce_y = 1'b1;
            end else if (paddle_hit) begin
              y_d      = Y_SERVE;
              dy_pos_d = 1'b0;
              bounce_y = 1'b1;
            end else begin
              y_d = ny[8:0];
            end

            bounce_d = bounce_x || bounce_y;
          end
        end

        ST_LOST: begin
          if (cnt_q == CW'(LOST_FRAMES - 1)) begin
            state_d  = ST_SERVE;
            cnt_d    = '0;
            dx_pos_d = 1'b1;
            dy_pos_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: state_d = ST_SERVE;
      endcase
    end
  end

  // Unsigned wrap makes pixels left of / above the ball fail the compare.
  assign rel_x  = bus.i_x - x_q;
  assign rel_y  = bus.i_y - y_q;
  assign draw_d = (rel_x < 10'(BALL_SIZE)) && (rel_y < 9'(BALL_SIZE)) && (state_q != ST_LOST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_SERVE;
      x_q      <= X_RESET;
      y_q      <= Y_SERVE;
      dx_pos_q <= 1'b1;
      dy_pos_q <= 1'b0;
      launch_q <= 1'b0;
      cnt_q    <= '0;
      bounce_q <= 1'b0;
      lost_q   <= 1'b0;
      draw_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_pos_q <= dx_pos_d;
      dy_pos_q <= dy_pos_d;
      launch_q <= launch_d;
      cnt_q    <= cnt_d;
      bounce_q <= bounce_d;
      lost_q   <= lost_d;
      draw_q   <= draw_d;
    end
  end

  assign bus.o_ball_x = x_q;
  assign bus.o_ball_y = y_q;
  assign bus.o_state  = state_q;
  assign bus.o_bounce = bounce_q;
  assign bus.o_lost   = lost_q;
  assign bus.o_draw   = draw_q;

endmodule

// File: tb/tb_arkanoid_ball.sv
// Scoreboard bench for arkanoid_ball: stimulus queues hand-computed responses, a monitor compares them.
module tb_arkanoid_ball;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic probe = 1'b0;

  always #5 clk = ~clk;

  arkanoid_ball_if bus ();

  arkanoid_ball dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // mask bits: 0=x 1=y 2=state 3=bounce 4=lost 5=draw
  typedef struct {
    string      name;
    bit         lag;
    bit [5:0]   mask;
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] st;
    logic       bnc;
    logic       lst;
    logic       drw;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input exp_t e);
    bit ok;
    ok = 1'b1;
    if (e.mask[0] && bus.o_ball_x !== e.x)   ok = 1'b0;
    if (e.mask[1] && bus.o_ball_y !== e.y)   ok = 1'b0;
    if (e.mask[2] && bus.o_state  !== e.st)  ok = 1'b0;
    if (e.mask[3] && bus.o_bounce !== e.bnc) ok = 1'b0;
    if (e.mask[4] && bus.o_lost   !== e.lst) ok = 1'b0;
    if (e.mask[5] && bus.o_draw   !== e.drw) ok = 1'b0;
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got x=%0d y=%0d state=%0d bounce=%0b lost=%0b draw=%0b; want x=%0d y=%0d state=%0d bounce=%0b lost=%0b draw=%0b (fields %b)",
                  e.name, bus.o_ball_x, bus.o_ball_y, bus.o_state, bus.o_bounce, bus.o_lost, bus.o_draw,
                  e.x, e.y, e.st, e.bnc, e.lst, e.drw, e.mask);
  endtask

  task automatic push(input string name, input bit lag, input bit [5:0] mask,
                      input int x, input int y, input int st,
                      input bit bnc, input bit lst, input bit drw);
    exp_t e;
    e.name = name; e.lag = lag; e.mask = mask;
    e.x = 10'(x); e.y = 9'(y); e.st = 2'(st);
    e.bnc = bnc; e.lst = lst; e.drw = drw;
    sb.push_back(e);
  endtask

  task automatic exp_pos(input string name, input int x, input int y, input int st,
                         input bit bnc, input bit lst);
    push(name, 1'b1, 6'b011111, x, y, st, bnc, lst, 1'b0);
  endtask

  task automatic exp_st(input string name, input int st, input bit bnc, input bit lst);
    push(name, 1'b1, 6'b011100, 0, 0, st, bnc, lst, 1'b0);
  endtask

  // Monitor: a rising i_animate or a probe strobe marks a DUT response; lag selects same or next sample.
  initial begin
    bit pending;
    logic anim_prev;
    pending   = 1'b0;
    anim_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (pending) begin
        pending = 1'b0;
        check(sb.pop_front());
      end
      if (((bus.i_animate && !anim_prev) || probe) && sb.size() > 0) begin
        if (sb[0].lag) pending = 1'b1;
        else           check(sb.pop_front());
      end
      anim_prev = bus.i_animate;
    end
  end

  task automatic tick();
    @(posedge clk); #1 bus.i_animate = 1'b1;
    @(posedge clk); #1 bus.i_animate = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic launch_pulse();
    @(posedge clk); #1 bus.i_launch = 1'b1;
    @(posedge clk); #1 bus.i_launch = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic launch_with_tick();
    @(posedge clk); #1 bus.i_launch = 1'b1; bus.i_animate = 1'b1;
    @(posedge clk); #1 bus.i_launch = 1'b0; bus.i_animate = 1'b0;
  endtask

  task automatic probe_draw(input string name, input int x, input int y, input bit drw);
    @(posedge clk); #1
    bus.i_x = 10'(x);
    bus.i_y = 9'(y);
    push(name, 1'b1, 6'b100000, 0, 0, 0, 1'b0, 1'b0, drw);
    probe = 1'b1;
    @(posedge clk); #1 probe = 1'b0;
  endtask

  task automatic reset_check(input string name);
    @(posedge clk); #1
    rst_n = 1'b0;
    push(name, 1'b0, 6'b111111, 316, 432, 0, 1'b0, 1'b0, 1'b0);
    probe = 1'b1;
    @(posedge clk); #1 probe = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_animate  = 1'b0;
    bus.i_launch   = 1'b0;
    bus.i_paddle_x = 10'd288;
    bus.i_x        = 10'd0;
    bus.i_y        = 9'd0;

    // Reset state and draw window around (316, 432)
    reset_check("reset_state");
    release_reset();
    probe_draw("draw_origin", 316, 432, 1'b1);
    probe_draw("draw_right_edge", 324, 432, 1'b0);
    probe_draw("draw_far_corner", 323, 439, 1'b1);
    probe_draw("draw_left_wrap", 315, 432, 1'b0);

    // Serve tracking with clamp at the right edge
    bus.i_paddle_x = 10'd100;
    exp_pos("serve_track_100", 128, 432, 0, 1'b0, 1'b0); tick();
    bus.i_paddle_x = 10'd620;
    exp_pos("serve_clamp_620", 632, 432, 0, 1'b0, 1'b0); tick();
    bus.i_paddle_x = 10'd288;
    exp_pos("serve_track_288", 316, 432, 0, 1'b0, 1'b0); tick();

    // Launch latched without a tick, consumed by the next tick
    launch_pulse();
    exp_pos("launch_to_move", 316, 432, 1, 1'b0, 1'b0); tick();
    ticks(157);
    exp_pos("right_wall_k158", 632, 116, 1, 1'b1, 1'b0); tick();
    ticks(56);
    exp_pos("before_top_k215", 518, 2, 1, 1'b0, 1'b0); tick();
    exp_pos("top_wall_k216", 516, 0, 1, 1'b1, 1'b0); tick();
    exp_pos("after_top_k217", 514, 2, 1, 1'b0, 1'b0); tick();

    // Corner at (632, 0), then paddle hit on the way down
    reset_check("reset_before_corner");
    release_reset();
    bus.i_paddle_x = 10'd172;
    exp_pos("serve_track_172", 200, 432, 0, 1'b0, 1'b0); tick();
    exp_pos("launch_same_tick", 200, 432, 1, 1'b0, 1'b0); launch_with_tick();
    ticks(214);
    exp_pos("corner_approach", 630, 2, 1, 1'b0, 1'b0); tick();
    exp_pos("corner_both_axes", 632, 0, 1, 1'b1, 1'b0); tick();
    exp_pos("corner_after", 630, 2, 1, 1'b0, 1'b0); tick();
    ticks(213);
    exp_pos("falling_y430", 202, 430, 1, 1'b0, 1'b0); tick();
    exp_pos("paddle_hit", 200, 432, 1, 1'b1, 1'b0); tick();
    exp_pos("paddle_rebound", 198, 430, 1, 1'b0, 1'b0); tick();

    // Same path with the paddle moved away: miss, loss, LOST timeout
    @(posedge clk); #1 rst_n = 1'b0;
    release_reset();
    bus.i_paddle_x = 10'd172;
    tick();
    launch_with_tick();
    bus.i_paddle_x = 10'd400;
    ticks(216 + 215);
    exp_pos("paddle_miss", 200, 432, 1, 1'b0, 1'b0); tick();
    ticks(18);
    exp_pos("near_bottom", 162, 470, 1, 1'b0, 1'b0); tick();
    exp_st("bottom_lost", 2, 1'b0, 1'b1); tick();
    probe_draw("draw_gated_lost", 162, 470, 1'b0);
    launch_pulse();
    exp_st("lost_pulse_once", 2, 1'b0, 1'b0); tick();
    ticks(57);
    exp_st("lost_tick59", 2, 1'b0, 1'b0); tick();
    exp_st("lost_tick60_serve", 0, 1'b0, 1'b0); tick();
    exp_pos("serve_after_lost", 428, 432, 0, 1'b0, 1'b0); tick();

    // Long animate pulse advances once; async reset mid-move
    launch_pulse();
    exp_pos("relaunch", 428, 432, 1, 1'b0, 1'b0); tick();
    exp_pos("long_animate", 430, 430, 1, 1'b0, 1'b0);
    @(posedge clk); #1 bus.i_animate = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.i_animate = 1'b0;
    exp_pos("after_long_animate", 432, 428, 1, 1'b0, 1'b0); tick();
    reset_check("reset_mid_move");
    release_reset();

    repeat (3) @(posedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      $display("FAIL %s: no DUT response observed, want x=%0d y=%0d state=%0d", e.name, e.x, e.y, e.st);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
